mul_unit: RTL

MUL_UNIT -- requirements
Module: mul_unit

---
 rtl/mul_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier: MUL, MLA, UMULL and SMULL in WIDTH cycles.
// Results and flags are registered on entry to DONE and hold until the next DONE.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic [1:0]       Flags,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MLA   = 2'b01;
  localparam logic [1:0] OP_UMULL = 2'b10;
  localparam logic [1:0] OP_SMULL = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       flags;
  } result_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   addend_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_add;
  logic               accept;
  logic               last;
  result_t            fin;

  // Two's-complement magnitude; the most-negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
    logic signed [WIDTH-1:0] neg_x;
    neg_x = -x;
    return (x < 0) ? neg_x : x;
  endfunction

  function automatic result_t finalize(input logic [1:0]         op,
                                       input logic [2*WIDTH-1:0] p,
                                       input logic [WIDTH-1:0]   addend,
                                       input logic               neg);
    result_t            r;
    logic [2*WIDTH-1:0] full;
    r    = '0;
    full = p;
    unique case (op)
      OP_MUL, OP_MLA: begin
        r.lo    = (op == OP_MLA) ? p[WIDTH-1:0] + addend : p[WIDTH-1:0];
        r.hi    = '0;
        r.flags = {r.lo[WIDTH-1], r.lo == '0};
      end
      default: begin
        if (op == OP_SMULL && neg) full = -p;
        r.hi    = full[2*WIDTH-1:WIDTH];
        r.lo    = full[WIDTH-1:0];
        r.flags = {full[2*WIDTH-1], full == '0};
      end
    endcase
    return r;
  endfunction

  assign accept   = start && (state == IDLE || state == DONE);
  assign last     = (state == RUN) && (cnt == CW'(1));
  assign prod_add = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign fin      = finalize(op_q, prod_add, addend_q, neg_q);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operand capture, one multiplier bit retired per RUN cycle, result commit on the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      op_q     <= '0;
      addend_q <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      ResultLo <= '0;
      ResultHi <= '0;
      Flags    <= '0;
    end else if (accept) begin
      cnt      <= CW'(WIDTH);
      op_q     <= Op;
      addend_q <= acc;
      prod_q   <= '0;
      if (Op == OP_SMULL) begin
        neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
        mcand_q  <= {{WIDTH{1'b0}}, magnitude(a)};
        mplier_q <= magnitude(b);
      end else begin
        neg_q    <= 1'b0;
        mcand_q  <= {{WIDTH{1'b0}}, a};
        mplier_q <= b;
      end
    end else if (state == RUN) begin
      cnt      <= cnt - CW'(1);
      prod_q   <= prod_add;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (last) begin
        ResultLo <= fin.lo;
        ResultHi <= fin.hi;
        Flags    <= fin.flags;
      end
    end
  end

endmodule
